uart_rx_oversampled: RTL

Serial receive side of the UART: recovers 8-N-1 frames from the `rx` line using a free-running 16x oversampling tick generated internally from `clk`. Received bytes are presented on a valid/ready holding register to the host logic, with per-frame framing-error and overrun flags. It is the counterpart to the transmit path and its baud-tick counter, and shares the same system clock.

---
 rtl/uart_rx_oversampled.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/uart_rx_oversampled.sv
// 8-N-1 UART receiver with a free-running 16x oversample tick.
// Received bytes sit in a valid/ready holding register with error pulses.
module uart_rx_oversampled #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int DVSR    = 27
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  output logic [DBIT-1:0] rx_dout,
  output logic            rx_valid,
  input  logic            rx_ready,
  output logic            frame_err,
  output logic            overrun_err
);

  localparam int CW = $clog2(DVSR);
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DVSR - 1);
  localparam logic [NW-1:0] NMAX = NW'(DBIT - 1);
  localparam logic [3:0]    SMAX = 4'(SB_TICK - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t          state, state_n;
  logic            sync1, rx_s;
  logic [CW-1:0]   cnt;
  logic            tick;
  logic [3:0]      s, s_n;
  logic [NW-1:0]   n, n_n;
  logic [DBIT-1:0] b, b_n;
  logic            done;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx;
      rx_s  <= sync1;
    end
  end

  assign tick = (cnt == CMAX);

  always_ff @(posedge clk) begin
    if (reset || tick) cnt <= '0;
    else               cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      s     <= '0;
      n     <= '0;
      b     <= '0;
    end else begin
      state <= state_n;
      s     <= s_n;
      n     <= n_n;
      b     <= b_n;
    end
  end

  always_comb begin
    state_n = state;
    s_n     = s;
    n_n     = n;
    b_n     = b;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          s_n     = '0;
        end
      end
      START: begin
        if (tick) begin
          // mid-start-bit check rejects short glitches
          if (s == 4'd7) begin
            if (!rx_s) begin
              state_n = DATA;
              s_n     = '0;
              n_n     = '0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            s_n = s + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s == 4'd15) begin
            s_n = '0;
            b_n = {rx_s, b[DBIT-1:1]};
            if (n == NMAX) state_n = STOP;
            else           n_n = n + 1'b1;
          end else begin
            s_n = s + 4'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s == SMAX) begin
            state_n = IDLE;
            done    = 1'b1;
          end else begin
            s_n = s + 4'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_dout     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= done && !rx_s;
      overrun_err <= done && rx_s && rx_valid && !rx_ready;
      // a consume coinciding with a new byte keeps valid high
      if (done && rx_s) begin
        rx_dout  <= b;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
